// File: rtl/xmpl_dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xmpl_dsp_pkg
//  Purpose  : Shared constants, state encoding and helpers for the decimator
//  Revision : 1.0 - initial release
// ============================================================================
package xmpl_dsp_pkg;

  localparam int SMP_W        = 12;
  localparam int DEC_LOG2_MAX = 4;
  localparam int ACC_W        = SMP_W + DEC_LOG2_MAX;
  localparam int ABORT_CNT_W  = 8;
  localparam int LOG2_W       = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } dec_state_e;

  // Limit a requested log2 ratio to the largest window the accumulator holds.
  function automatic logic [LOG2_W-1:0] clamp_log2(input logic [LOG2_W-1:0] l,
                                                   input int               max_l);
    logic [LOG2_W-1:0] c_max;
    c_max = LOG2_W'(max_l);
    if (l > c_max) begin
      return c_max;
    end
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xmpl_dsp_dec_round.sv
`default_nettype none
// ============================================================================
//  Module   : xmpl_dsp_dec_round
//  Purpose  : Combinational round-half-up and right shift of an accumulator
//             sum down to sample width. Shared by decimating stages.
//  Revision : 1.0 - initial release
// ============================================================================
module xmpl_dsp_dec_round #(
  parameter int ACC_W  = 16,
  parameter int SMP_W  = 12,
  parameter int LOG2_W = 3
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [LOG2_W-1:0] i_log2,
  output logic [SMP_W-1:0]  o_avg
);

  import xmpl_dsp_pkg::*;

  logic [ACC_W-1:0] w_rnd;
  logic [ACC_W-1:0] w_sum;

  // Add half an LSB of the result (nothing for a shift of zero), then shift.
  // The caller guarantees the sum cannot overflow ACC_W.
  always_comb begin
    w_rnd = '0;
    if (i_log2 != '0) begin
      w_rnd = ACC_W'(1) << (i_log2 - LOG2_W'(1));
    end
    w_sum = i_acc + w_rnd;
    o_avg = SMP_W'(w_sum >> i_log2);
  end

endmodule
`default_nettype wire

// File: rtl/xmpl_dsp_dec.sv
`default_nettype none
// ============================================================================
//  Module   : xmpl_dsp_dec
//  Purpose  : Boxcar decimator. Averages windows of 2^L unsigned samples and
//             emits one rounded average per window as strobe + held data.
//  Revision : 1.0 - initial release
// ============================================================================
module xmpl_dsp_dec #(
  parameter int SMP_W        = 12,
  parameter int DEC_LOG2_MAX = 4,
  parameter int ABORT_CNT_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   dec_en_i,
  input  logic [2:0]             dec_log2_i,
  input  logic                   smp_valid_i,
  output logic                   smp_ready_o,
  input  logic [SMP_W-1:0]       smp_data_i,
  output logic                   xmpl_dsp_msf_a_o,
  output logic [SMP_W-1:0]       xmpl_dsp_msf_b_o,
  output logic                   dec_busy_o,
  output logic [ABORT_CNT_W-1:0] dec_abort_cnt_o
);

  import xmpl_dsp_pkg::*;

  localparam int ACC_W = SMP_W + DEC_LOG2_MAX;
  localparam int CNT_W = DEC_LOG2_MAX;

  dec_state_e             r_state;
  dec_state_e             w_state_nxt;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       w_acc_nxt;
  logic [ACC_W-1:0]       w_acc_sum;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_last;
  logic [2:0]             r_l_lat;
  logic [2:0]             w_l_nxt;
  logic                   r_strobe;
  logic                   w_strobe_nxt;
  logic [SMP_W-1:0]       r_avg;
  logic [SMP_W-1:0]       w_avg_nxt;
  logic [SMP_W-1:0]       w_avg;
  logic                   r_busy;
  logic [ABORT_CNT_W-1:0] r_abort;
  logic [ABORT_CNT_W-1:0] w_abort_nxt;
  logic                   w_accept;

  // Ready is purely a function of state and enable: nothing downstream stalls.
  assign smp_ready_o = (r_state == ACC) && dec_en_i;
  assign w_accept    = smp_ready_o && smp_valid_i;

  // Running sum including the sample on the bus; this is the window total
  // when the current accept closes the window.
  assign w_acc_sum  = r_acc + ACC_W'(smp_data_i);
  assign w_cnt_last = CNT_W'((32'd1 << r_l_lat) - 32'd1);

  xmpl_dsp_dec_round #(
    .ACC_W  (ACC_W),
    .SMP_W  (SMP_W),
    .LOG2_W (3)
  ) u_round (
    .i_acc  (w_acc_sum),
    .i_log2 (r_l_lat),
    .o_avg  (w_avg)
  );

  // Next-state and datapath updates: window start, accumulate, window close,
  // and abort of a partially filled window on disable.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_l_nxt      = r_l_lat;
    w_strobe_nxt = 1'b0;
    w_avg_nxt    = r_avg;
    w_abort_nxt  = r_abort;
    case (r_state)
      IDLE: begin
        if (dec_en_i) begin
          w_state_nxt = ACC;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_l_nxt     = clamp_log2(dec_log2_i, DEC_LOG2_MAX);
        end
      end
      ACC: begin
        if (!dec_en_i) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          if ((r_cnt != '0) && (r_abort != '1)) begin
            w_abort_nxt = r_abort + ABORT_CNT_W'(1);
          end
        end else if (w_accept) begin
          if (r_cnt == w_cnt_last) begin
            // Close the window and start the next one with no bubble.
            w_strobe_nxt = 1'b1;
            w_avg_nxt    = w_avg;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_l_nxt      = clamp_log2(dec_log2_i, DEC_LOG2_MAX);
          end else begin
            w_acc_nxt = w_acc_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any pending strobe.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_l_lat  <= '0;
      r_strobe <= 1'b0;
      r_avg    <= '0;
      r_busy   <= 1'b0;
      r_abort  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_l_lat  <= w_l_nxt;
      r_strobe <= w_strobe_nxt;
      r_avg    <= w_avg_nxt;
      r_busy   <= (w_cnt_nxt != '0);
      r_abort  <= w_abort_nxt;
    end
  end

  assign xmpl_dsp_msf_a_o = r_strobe;
  assign xmpl_dsp_msf_b_o = r_avg;
  assign dec_busy_o       = r_busy;
  assign dec_abort_cnt_o  = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_xmpl_dsp_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xmpl_dsp_dec
//  Purpose  : Directed self-checking bench for the boxcar decimator
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xmpl_dsp_dec;

  logic        clk_i;
  logic        reset_n_i;
  logic        dec_en_i;
  logic [2:0]  dec_log2_i;
  logic        smp_valid_i;
  logic        smp_ready_o;
  logic [11:0] smp_data_i;
  logic        xmpl_dsp_msf_a_o;
  logic [11:0] xmpl_dsp_msf_b_o;
  logic        dec_busy_o;
  logic [7:0]  dec_abort_cnt_o;

  int errors;
  int checks;

  xmpl_dsp_dec dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .dec_en_i         (dec_en_i),
    .dec_log2_i       (dec_log2_i),
    .smp_valid_i      (smp_valid_i),
    .smp_ready_o      (smp_ready_o),
    .smp_data_i       (smp_data_i),
    .xmpl_dsp_msf_a_o (xmpl_dsp_msf_a_o),
    .xmpl_dsp_msf_b_o (xmpl_dsp_msf_b_o),
    .dec_busy_o       (dec_busy_o),
    .dec_abort_cnt_o  (dec_abort_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Present one sample, confirm ready, clock it in, check strobe and data.
  task automatic send(input string tag, input int d, input bit ea, input int eb);
    smp_valid_i = 1'b1;
    smp_data_i  = d[11:0];
    #1;
    check({tag, "_ready"}, {31'd0, smp_ready_o}, 32'd1);
    cyc();
    check({tag, "_strobe"}, {31'd0, xmpl_dsp_msf_a_o}, {31'd0, ea});
    check({tag, "_data"}, {20'd0, xmpl_dsp_msf_b_o}, eb);
  endtask

  // Leave ACC for one edge, then re-enter with a new ratio.
  task automatic restart(input logic [2:0] l);
    smp_valid_i = 1'b0;
    dec_en_i    = 1'b0;
    cyc();
    dec_en_i    = 1'b1;
    dec_log2_i  = l;
    cyc();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset_n_i   = 1'b0;
    dec_en_i    = 1'b0;
    dec_log2_i  = 3'd0;
    smp_valid_i = 1'b0;
    smp_data_i  = 12'd0;
    #3;
    check("rst_ready", {31'd0, smp_ready_o}, 32'd0);
    check("rst_strobe", {31'd0, xmpl_dsp_msf_a_o}, 32'd0);
    check("rst_data", {20'd0, xmpl_dsp_msf_b_o}, 32'd0);
    check("rst_busy", {31'd0, dec_busy_o}, 32'd0);
    check("rst_abort", {24'd0, dec_abort_cnt_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // L=2: 100..103 -> (406+2)>>2 = 102
    dec_en_i   = 1'b1;
    dec_log2_i = 3'd2;
    cyc();
    send("l2_s0", 100, 1'b0, 0);
    check("l2_busy", {31'd0, dec_busy_o}, 32'd1);
    send("l2_s1", 101, 1'b0, 0);
    send("l2_s2", 102, 1'b0, 0);
    send("l2_s3", 103, 1'b1, 102);
    smp_valid_i = 1'b0;
    cyc();
    check("l2_strobe_one_cycle", {31'd0, xmpl_dsp_msf_a_o}, 32'd0);
    check("l2_hold", {20'd0, xmpl_dsp_msf_b_o}, 32'd102);
    check("l2_busy_clear", {31'd0, dec_busy_o}, 32'd0);

    // L=0: every accept strobes
    restart(3'd0);
    check("idle_disable_no_abort", {24'd0, dec_abort_cnt_o}, 32'd0);
    send("l0_s0", 7, 1'b1, 7);
    send("l0_s1", 4095, 1'b1, 4095);
    send("l0_s2", 0, 1'b1, 0);
    smp_valid_i = 1'b0;
    cyc();
    check("l0_idle_strobe", {31'd0, xmpl_dsp_msf_a_o}, 32'd0);

    // L=4: 16x4095 -> (65520+8)>>4 = 4095, then 16x1 -> (16+8)>>4 = 1
    restart(3'd4);
    for (int i = 0; i < 16; i++) send("l4_max", 4095, (i == 15), (i == 15) ? 4095 : 0);
    for (int i = 0; i < 16; i++) send("l4_one", 1, (i == 15), (i == 15) ? 1 : 4095);

    // L=1: 1,2 -> (3+1)>>1 = 2 ; 1,1 -> (2+1)>>1 = 1
    restart(3'd1);
    send("l1_a0", 1, 1'b0, 1);
    send("l1_a1", 2, 1'b1, 2);
    send("l1_b0", 1, 1'b0, 2);
    send("l1_b1", 1, 1'b1, 1);

    // L=3: abort after 5 samples
    restart(3'd3);
    for (int i = 0; i < 5; i++) send("l3_part", 10, 1'b0, 1);
    check("l3_busy_before", {31'd0, dec_busy_o}, 32'd1);
    dec_en_i = 1'b0;
    #1;
    check("l3_ready_drop", {31'd0, smp_ready_o}, 32'd0);
    cyc();
    check("l3_abort_strobe", {31'd0, xmpl_dsp_msf_a_o}, 32'd0);
    check("l3_busy_after", {31'd0, dec_busy_o}, 32'd0);
    check("l3_abort_cnt", {24'd0, dec_abort_cnt_o}, 32'd1);
    dec_en_i    = 1'b1;
    smp_valid_i = 1'b0;
    cyc();
    // 8x10 -> (80+4)>>3 = 10
    for (int i = 0; i < 8; i++) send("l3_full", 10, (i == 7), (i == 7) ? 10 : 1);
    // Disable right after the closing accept: window already empty, no abort
    smp_valid_i = 1'b0;
    dec_en_i    = 1'b0;
    cyc();
    check("inflight_no_abort", {24'd0, dec_abort_cnt_o}, 32'd1);

    // Clamp: request 7 -> 4; 16x8 -> (128+8)>>4 = 8; ratio change mid-window
    dec_en_i   = 1'b1;
    dec_log2_i = 3'd7;
    cyc();
    for (int i = 0; i < 16; i++) begin
      if (i == 4) dec_log2_i = 3'd0;
      send("clamp", 8, (i == 15), (i == 15) ? 8 : 10);
    end
    send("after_change", 5, 1'b1, 5);

    // Async reset mid-window clears state immediately
    dec_log2_i = 3'd2;
    send("pre_rst0", 9, 1'b1, 9);
    send("pre_rst1", 3, 1'b0, 9);
    check("pre_rst_busy", {31'd0, dec_busy_o}, 32'd1);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    check("arst_busy", {31'd0, dec_busy_o}, 32'd0);
    check("arst_data", {20'd0, xmpl_dsp_msf_b_o}, 32'd0);
    check("arst_ready", {31'd0, smp_ready_o}, 32'd0);
    check("arst_abort", {24'd0, dec_abort_cnt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xmpl_dsp_dec.md
Name: xmpl_dsp_dec

Overview:
Boxcar decimator feeding the xmpl_dsp_msf stage inside xmpl_dsp_ctrl.
- Accepts 12-bit raw samples over a valid/ready handshake and averages windows of 2^L samples.
- Emits one rounded 12-bit average per window as a single-cycle strobe plus data, which drive xmpl_dsp_msf's a/b inputs.
- Provides busy and abort status for the control block.

Parameters:
SMP_W, 12, sample and output data width
DEC_LOG2_MAX, 4, maximum log2 decimation ratio; larger requests clamp to this
ABORT_CNT_W, 8, width of saturating abort counter

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
dec_en_i  input  1  decimator enable
dec_log2_i  input  3  log2 decimation ratio L (0..4; values >4 treated as 4)
smp_valid_i  input  1  input sample valid
smp_ready_o  output  1  input sample ready
smp_data_i  input  SMP_W  input sample, unsigned
xmpl_dsp_msf_a_o  output  1  one-cycle result strobe to msf
xmpl_dsp_msf_b_o  output  SMP_W  averaged result to msf; held between strobes
dec_busy_o  output  1  high while a window is partially filled (cnt != 0)
dec_abort_cnt_o  output  ABORT_CNT_W  count of aborted partial windows, saturating at 255

Behaviour:
- Clock and reset: single clock clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values:
  - state=IDLE; acc=0; cnt=0; latched L=0.
  - xmpl_dsp_msf_a_o=0, xmpl_dsp_msf_b_o=0, dec_busy_o=0, dec_abort_cnt_o=0.
  - smp_ready_o=0.
- States:
  - IDLE -> ACC when dec_en_i=1. On entry to ACC: L_lat = min(dec_log2_i, 4); acc=0; cnt=0.
  - ACC -> IDLE when dec_en_i=0.
- Handshake:
  - smp_ready_o = (state==ACC) && dec_en_i. This is combinational; no backpressure comes from downstream.
  - A sample is accepted when smp_valid_i && smp_ready_o.
- Accumulate:
  - On accept: acc += smp_data_i; cnt += 1.
  - ACC_W = SMP_W + DEC_LOG2_MAX = 16 bits, unsigned.
- Window end, on accept with cnt == 2^L_lat - 1:
  - Next cycle, xmpl_dsp_msf_a_o=1 for exactly one cycle.
  - xmpl_dsp_msf_b_o = (acc_final + (L_lat ? 2^(L_lat-1) : 0)) >> L_lat, where acc_final includes the accepted sample.
  - acc_final + round is at most 65528, which fits in 16 bits, so the result is at most 4095 and needs no saturation.
  - Same cycle: acc, cnt cleared; L_lat re-latched from dec_log2_i.
  - Ready stays high, so back-to-back windows run with no bubble.
- Latency: 1 cycle from last accepted sample to strobe. With L=0 every accepted sample produces a strobe one cycle later.
- Mid-window ratio change: dec_log2_i is ignored until the next window boundary.
- Disable mid-window (dec_en_i=0 while cnt != 0):
  - No accept occurs that cycle, because ready drops combinationally.
  - Next cycle: state=IDLE; acc=0; cnt=0; dec_abort_cnt_o += 1 (saturating at 255); no strobe.
  - Disable with cnt == 0: no abort count.
- Strobe in flight: a strobe already scheduled (last sample accepted) still fires if dec_en_i falls in the following cycle.
- dec_busy_o: registered; equals (cnt != 0).
- Async reset mid-window: all state cleared immediately; a pending strobe is lost.

Decomposition:
- Package xmpl_dsp_pkg holds:
  - SMP_W, DEC_LOG2_MAX, ACC_W = SMP_W + DEC_LOG2_MAX
  - dec_state_e {IDLE, ACC}
  - function clamp_log2()
- One natural sub-module: xmpl_dsp_dec_round, a combinational round-and-shift of ACC_W to SMP_W by L. It is reusable by other decimating stages.
- All remaining logic stays in xmpl_dsp_dec.

Test Plan:
- L=2, en=1, continuous valid, samples 100,101,102,103 -> one strobe 1 cycle after 103 accepted, b=102 (406+2 >> 2); ready never drops.
- L=0, samples 7,4095,0 -> three strobes on consecutive cycles, b=7,4095,0, each 1 cycle after accept.
- L=4, 16 samples of 4095 back-to-back, then 16 samples of 1 -> strobes with b=4095, then b=1; no bubble between windows.
- L=1, samples 1,2 -> b=2 (rounding of 1.5 up); samples 1,1 -> b=1.
- L=3, accept 5 samples, then drop en for 1 cycle and raise it again -> no strobe, dec_abort_cnt_o=1, busy 1->0; next 8 samples of 10 -> b=10.
- dec_log2_i=7 with 16 samples of 8 -> single strobe after the 16th, b=8 (clamped to 4). Change dec_log2_i to 0 mid-window -> takes effect only after that strobe.
